pipe_result_rx: RTL



---
 rtl/pipe_result_rx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pipe_result_rx.sv
// ============================================================================
// Module   : pipe_result_rx
// Purpose  : Buffers the multiply-add pipe's result beats in a FIFO and sums
//            each frame. Optional macro PIPE_RESULT_RX_MAX_EN adds frame_max.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_result_rx #(
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     clr,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [11:0]              frame_sum,
`ifdef PIPE_RESULT_RX_MAX_EN
  output logic [7:0]               frame_max,
`endif
  output logic                     sum_valid
);

  localparam int              c_AW   = $clog2(DEPTH);
  localparam int              c_CW   = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
  localparam logic [4:0]      c_LAST = 5'(FRAME_LEN - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  logic [7:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic            r_overflow;
  state_t          r_state;
  logic [4:0]      r_beat;
  logic [11:0]     r_psum;
  logic [11:0]     r_frame_sum;
  logic            r_sum_valid;

  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic            w_last;
  logic [11:0]     w_sum_next;

  assign w_full = (r_count == c_FULL);
  assign w_pop  = (r_count != '0) && out_ready;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign w_push = in_valid && (!w_full || w_pop);
  assign w_drop = in_valid && w_full && !w_pop;

  // In IDLE the beat counter is 0, so FRAME_LEN==1 completes on the first beat.
  assign w_last     = (r_beat == c_LAST);
  assign w_sum_next = (r_state == IDLE) ? {4'd0, in_data} : (r_psum + {4'd0, in_data});

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_psum      <= '0;
      r_frame_sum <= '0;
      r_sum_valid <= 1'b0;
    end else if (clr) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_psum      <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      r_sum_valid <= 1'b0;
      if (w_push) begin
        if (w_last) begin
          r_frame_sum <= w_sum_next;
          r_sum_valid <= 1'b1;
          r_state     <= IDLE;
          r_beat      <= '0;
          r_psum      <= '0;
        end else begin
          r_psum  <= w_sum_next;
          r_beat  <= r_beat + 5'd1;
          r_state <= ACCUM;
        end
      end
    end
  end

`ifdef PIPE_RESULT_RX_MAX_EN
  logic [7:0] r_pmax;
  logic [7:0] r_frame_max;
  logic [7:0] w_max_next;

  assign w_max_next = ((r_state == IDLE) || (in_data > r_pmax)) ? in_data : r_pmax;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pmax      <= '0;
      r_frame_max <= '0;
    end else if (clr) begin
      r_pmax <= '0;
    end else if (w_push) begin
      if (w_last) begin
        r_frame_max <= w_max_next;
        r_pmax      <= '0;
      end else begin
        r_pmax <= w_max_next;
      end
    end
  end

  assign frame_max = r_frame_max;
`endif

  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : 8'd0;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign frame_sum = r_frame_sum;
  assign sum_valid = r_sum_valid;

endmodule

`default_nettype wire
